// File: rtl/c7bcsr_timer_ctrl.sv
// CSR front end for the constant timer: holds TCFG, drives the timer controls,
// serves TCFG/TVAL/TICLR reads and keeps the sticky TI pending bit.
module c7bcsr_timer_ctrl #(
  parameter int          TIMER_BIT  = 30,
  parameter logic [13:0] ADDR_TCFG  = 14'h41,
  parameter logic [13:0] ADDR_TVAL  = 14'h42,
  parameter logic [13:0] ADDR_TICLR = 14'h44
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 csr_wr_en,
  input  logic [13:0]          csr_wr_addr,
  input  logic [31:0]          csr_wr_data,
  input  logic [31:0]          csr_wr_mask,
  input  logic [13:0]          csr_rd_addr,
  output logic [31:0]          csr_rd_data,
  output logic                 csr_rd_hit,
  output logic                 timer_init,
  output logic                 timer_en,
  output logic                 timer_periodic,
  output logic [TIMER_BIT-1:0] timer_initval,
  input  logic [TIMER_BIT+1:0] timer_timeval,
  input  logic                 timer_intr,
  output logic                 ti_pending
);

  localparam int TW = TIMER_BIT + 2;

  logic [TW-1:0] tcfg_q, tcfg_d;
  logic          init_q;
  logic          oneshot_q;
  logic          ti_q;
  logic          wr_tcfg, wr_ticlr, ti_clr;

  assign wr_tcfg  = csr_wr_en && (csr_wr_addr == ADDR_TCFG);
  assign wr_ticlr = csr_wr_en && (csr_wr_addr == ADDR_TICLR);
  assign ti_clr   = wr_ticlr && csr_wr_data[0] && csr_wr_mask[0];
  assign tcfg_d   = (tcfg_q & ~csr_wr_mask[TW-1:0]) | (csr_wr_data[TW-1:0] & csr_wr_mask[TW-1:0]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg_q    <= '0;
      init_q    <= 1'b0;
      oneshot_q <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      if (wr_tcfg) tcfg_q <= tcfg_d;
      // init follows every TCFG write so the timer reloads with the new InitVal/En
      init_q <= wr_tcfg;
      if (wr_tcfg)                       oneshot_q <= 1'b0;
      else if (timer_intr && !tcfg_q[1]) oneshot_q <= 1'b1;
      // an expiry in the same cycle as a clear must not be lost
      if (timer_intr)  ti_q <= 1'b1;
      else if (ti_clr) ti_q <= 1'b0;
    end
  end

  assign timer_init     = init_q;
  assign timer_en       = tcfg_q[0] & ~oneshot_q;
  assign timer_periodic = tcfg_q[1];
  assign timer_initval  = tcfg_q[TW-1:2];
  assign ti_pending     = ti_q;

  always_comb begin
    csr_rd_data = '0;
    csr_rd_hit  = 1'b0;
    if (csr_rd_addr == ADDR_TCFG) begin
      csr_rd_data[TW-1:0] = tcfg_q;
      csr_rd_hit          = 1'b1;
    end else if (csr_rd_addr == ADDR_TVAL) begin
      csr_rd_data[TW-1:0] = timer_timeval;
      csr_rd_hit          = 1'b1;
    end else if (csr_rd_addr == ADDR_TICLR) begin
      csr_rd_hit          = 1'b1;
    end
  end

endmodule

// File: tb/tb_c7bcsr_timer_ctrl.sv
// Directed bench for c7bcsr_timer_ctrl with a small behavioural timer attached.
module tb_c7bcsr_timer_ctrl;
  localparam int TB = 30;
  localparam logic [13:0] A_TCFG = 14'h41, A_TVAL = 14'h42, A_TICLR = 14'h44;

  logic          clk = 1'b0, resetn = 1'b0;
  logic          csr_wr_en = 1'b0;
  logic [13:0]   csr_wr_addr = '0, csr_rd_addr = '0;
  logic [31:0]   csr_wr_data = '0, csr_wr_mask = '0;
  logic [31:0]   csr_rd_data;
  logic          csr_rd_hit, timer_init, timer_en, timer_periodic, timer_intr, ti_pending;
  logic [TB-1:0] timer_initval;
  logic [TB+1:0] tv;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  c7bcsr_timer_ctrl #(.TIMER_BIT(TB)) dut (
    .clk(clk), .resetn(resetn), .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr),
    .csr_wr_data(csr_wr_data), .csr_wr_mask(csr_wr_mask), .csr_rd_addr(csr_rd_addr),
    .csr_rd_data(csr_rd_data), .csr_rd_hit(csr_rd_hit), .timer_init(timer_init),
    .timer_en(timer_en), .timer_periodic(timer_periodic), .timer_initval(timer_initval),
    .timer_timeval(tv), .timer_intr(timer_intr), .ti_pending(ti_pending));

  // Timer model: load on init, count down while enabled, expire at 0.
  assign timer_intr = timer_en && !timer_init && (tv == '0);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         tv <= '0;
    else if (timer_init) tv <= {timer_initval, 2'b00};
    else if (timer_en)   tv <= (tv == '0 && timer_periodic) ? {timer_initval, 2'b00} : tv - 1'b1;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
    csr_wr_en = 1'b1; csr_wr_addr = a; csr_wr_data = d; csr_wr_mask = m;
    cyc();
    csr_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a);
    csr_rd_addr = a; #1;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    resetn = 1'b1;
    cyc();
    rd(A_TCFG);
    n_cmp++; if (csr_rd_data !== 32'h0 || csr_rd_hit !== 1'b1) begin n_err++; $display("FAIL reset_tcfg got %h/%b want 0/1", csr_rd_data, csr_rd_hit); end
    rd(A_TVAL);
    n_cmp++; if (csr_rd_data !== 32'h0 || csr_rd_hit !== 1'b1) begin n_err++; $display("FAIL reset_tval got %h/%b want 0/1", csr_rd_data, csr_rd_hit); end
    rd(A_TICLR);
    n_cmp++; if (csr_rd_data !== 32'h0 || csr_rd_hit !== 1'b1) begin n_err++; $display("FAIL reset_ticlr got %h/%b want 0/1", csr_rd_data, csr_rd_hit); end
    rd(14'h40);
    n_cmp++; if (csr_rd_data !== 32'h0 || csr_rd_hit !== 1'b0) begin n_err++; $display("FAIL other_addr got %h/%b want 0/0", csr_rd_data, csr_rd_hit); end
    n_cmp++; if ({ti_pending, timer_en, timer_init, timer_periodic} !== 4'b0) begin n_err++; $display("FAIL reset_outs got %b want 0000", {ti_pending, timer_en, timer_init, timer_periodic}); end
  endtask

  task automatic test_oneshot();
    wr(A_TCFG, 32'h11, 32'hFFFF_FFFF);
    n_cmp++; if ({timer_init, timer_en, timer_periodic} !== 3'b110 || timer_initval !== 30'd4) begin n_err++; $display("FAIL os_ctrl got %b iv=%0d want 110 iv=4", {timer_init, timer_en, timer_periodic}, timer_initval); end
    rd(A_TVAL);
    cyc();
    n_cmp++; if (csr_rd_data !== 32'd16 || timer_init !== 1'b0) begin n_err++; $display("FAIL os_load got %0d init=%b want 16 init=0", csr_rd_data, timer_init); end
    for (int i = 15; i >= 0; i--) begin
      cyc();
      n_cmp++; if (csr_rd_data !== 32'(i)) begin n_err++; $display("FAIL os_count got %0d want %0d", csr_rd_data, i); end
    end
    n_cmp++; if (ti_pending !== 1'b0) begin n_err++; $display("FAIL os_ti_early got %b want 0", ti_pending); end
    cyc();
    n_cmp++; if (ti_pending !== 1'b1 || timer_en !== 1'b0 || csr_rd_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL os_done got ti=%b en=%b tval=%h want 1 0 ffffffff", ti_pending, timer_en, csr_rd_data); end
    cyc();
    n_cmp++; if (csr_rd_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL os_hold got %h want ffffffff", csr_rd_data); end
    rd(A_TCFG);
    n_cmp++; if (csr_rd_data !== 32'h11) begin n_err++; $display("FAIL os_tcfg got %h want 11", csr_rd_data); end
  endtask

  task automatic test_periodic();
    rd(A_TVAL);
    wr(A_TCFG, 32'h0B, 32'hFFFF_FFFF);
    n_cmp++; if ({timer_init, timer_en, timer_periodic, ti_pending} !== 4'b1111) begin n_err++; $display("FAIL per_ctrl got %b want 1111", {timer_init, timer_en, timer_periodic, ti_pending}); end
    cyc();
    n_cmp++; if (csr_rd_data !== 32'd8) begin n_err++; $display("FAIL per_load got %0d want 8", csr_rd_data); end
    repeat (8) cyc();
    n_cmp++; if (csr_rd_data !== 32'd0) begin n_err++; $display("FAIL per_zero got %0d want 0", csr_rd_data); end
    cyc();
    n_cmp++; if (csr_rd_data !== 32'd8) begin n_err++; $display("FAIL per_reload got %0d want 8", csr_rd_data); end
    wr(A_TICLR, 32'h1, 32'h1);
    n_cmp++; if (ti_pending !== 1'b0) begin n_err++; $display("FAIL per_clr got %b want 0", ti_pending); end
    repeat (7) cyc();
    n_cmp++; if (ti_pending !== 1'b0 || csr_rd_data !== 32'd0) begin n_err++; $display("FAIL per_pre got ti=%b tval=%0d want 0 0", ti_pending, csr_rd_data); end
    cyc();
    n_cmp++; if (ti_pending !== 1'b1 || csr_rd_data !== 32'd8) begin n_err++; $display("FAIL per_reset got ti=%b tval=%0d want 1 8", ti_pending, csr_rd_data); end
    wr(A_TICLR, 32'h1, 32'hFFFF_FFFE);
    n_cmp++; if (ti_pending !== 1'b1) begin n_err++; $display("FAIL ticlr_unmasked got %b want 1", ti_pending); end
  endtask

  task automatic test_clr_collision();
    wr(A_TICLR, 32'h1, 32'h1);
    repeat (6) cyc();
    n_cmp++; if (ti_pending !== 1'b0 || csr_rd_data !== 32'd0) begin n_err++; $display("FAIL coll_pre got ti=%b tval=%0d want 0 0", ti_pending, csr_rd_data); end
    wr(A_TICLR, 32'h1, 32'h1);
    n_cmp++; if (ti_pending !== 1'b1) begin n_err++; $display("FAIL coll_set_wins got %b want 1", ti_pending); end
  endtask

  task automatic test_masked();
    csr_wr_en = 1'b1; csr_wr_addr = A_TCFG; csr_wr_data = 32'h13; csr_wr_mask = 32'hFFFF_FFFF;
    rd(A_TCFG);
    n_cmp++; if (csr_rd_data !== 32'h0B) begin n_err++; $display("FAIL rd_prewrite got %h want 0b", csr_rd_data); end
    cyc();
    csr_wr_en = 1'b0;
    n_cmp++; if (csr_rd_data !== 32'h13) begin n_err++; $display("FAIL tcfg_13 got %h want 13", csr_rd_data); end
    repeat (2) cyc();
    wr(A_TCFG, 32'h0, 32'h1);
    n_cmp++; if (csr_rd_data !== 32'h12 || timer_init !== 1'b1 || timer_en !== 1'b0) begin n_err++; $display("FAIL masked got %h init=%b en=%b want 12 1 0", csr_rd_data, timer_init, timer_en); end
    rd(A_TVAL);
    cyc();
    n_cmp++; if (csr_rd_data !== 32'd16) begin n_err++; $display("FAIL masked_load got %0d want 16", csr_rd_data); end
    repeat (3) cyc();
    n_cmp++; if (csr_rd_data !== 32'd16 || timer_init !== 1'b0) begin n_err++; $display("FAIL frozen got %0d init=%b want 16 0", csr_rd_data, timer_init); end
    wr(A_TVAL, 32'h5, 32'hFFFF_FFFF);
    wr(14'h40, 32'hFF, 32'hFFFF_FFFF);
    rd(A_TCFG);
    n_cmp++; if (csr_rd_data !== 32'h12 || timer_init !== 1'b0) begin n_err++; $display("FAIL ignored_wr got %h init=%b want 12 0", csr_rd_data, timer_init); end
  endtask

  task automatic test_back_to_back();
    wr(A_TICLR, 32'h1, 32'h1);
    wr(A_TCFG, 32'h11, 32'hFFFF_FFFF);
    wr(A_TCFG, 32'h19, 32'hFFFF_FFFF);
    n_cmp++; if (timer_init !== 1'b1 || timer_en !== 1'b1 || timer_initval !== 30'd6) begin n_err++; $display("FAIL b2b got init=%b en=%b iv=%0d want 1 1 6", timer_init, timer_en, timer_initval); end
    rd(A_TVAL);
    cyc();
    n_cmp++; if (csr_rd_data !== 32'd24 || timer_init !== 1'b0) begin n_err++; $display("FAIL b2b_load got %0d init=%b want 24 0", csr_rd_data, timer_init); end
    repeat (24) cyc();
    n_cmp++; if (csr_rd_data !== 32'd0 || ti_pending !== 1'b0) begin n_err++; $display("FAIL b2b_zero got %0d ti=%b want 0 0", csr_rd_data, ti_pending); end
    // One-shot expiry and TCFG write on the same edge: the write keeps the timer enabled
    wr(A_TCFG, 32'h11, 32'hFFFF_FFFF);
    n_cmp++; if (timer_en !== 1'b1 || ti_pending !== 1'b1) begin n_err++; $display("FAIL os_clr_prio got en=%b ti=%b want 1 1", timer_en, ti_pending); end
    cyc();
    n_cmp++; if (csr_rd_data !== 32'd16) begin n_err++; $display("FAIL os_clr_load got %0d want 16", csr_rd_data); end
  endtask

  task automatic test_async_reset();
    repeat (3) cyc();
    rd(A_TCFG);
    #1 resetn = 1'b0;
    #1;
    n_cmp++; if (ti_pending !== 1'b0 || timer_en !== 1'b0 || csr_rd_data !== 32'h0) begin n_err++; $display("FAIL async_rst got ti=%b en=%b tcfg=%h want 0 0 0", ti_pending, timer_en, csr_rd_data); end
  endtask

  initial begin
    #1;
    test_reset();
    test_oneshot();
    test_periodic();
    test_clr_collision();
    test_masked();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
